stim_sequencer: RTL and testbench
=================================

STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, width of switch-drive and observe words.
REQ-002 Parameter DEPTH, default 32, number of script steps; AW = clog2(DEPTH).
REQ-003 Parameter WAIT_W, default 16, width of per-step wait count.
REQ-004 Parameter PULSE_LEN, default 10, cycles Continue_n is held low per pulse; range 1 to 255.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 Clk  in  1  system clock; all state updates on the rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  level; sampled only in IDLE and DONE.
REQ-009 wr_en  in  1  script write strobe.
REQ-010 wr_addr  in  AW  script step address.
REQ-011 wr_data  in  2+WAIT_W+DATA_W  step word, {op[1:0], wait, data}.
REQ-012 observe  in  DATA_W  value captured from the device under test.
REQ-013 S_out  out  DATA_W  switch value driven to the device.
REQ-014 Continue_n  out  1  active-low continue pulse.
REQ-015 Run_n  out  1  active-low run; low while busy.
REQ-016 busy  out  1  high in any state except IDLE and DONE.
REQ-017 done  out  1  high in DONE.
REQ-018 pass  out  1  high in DONE when fail_count == 0.
REQ-019 fail_count  out  8  number of mismatches; saturates at 255.
REQ-020 fail_step  out  AW  index of the first mismatching step.

Function
REQ-021 Op codes: 00 SET_S (S_out <= data), 01 PULSE (Continue_n low for PULSE_LEN cycles), 10 CHECK (compare observe to data), 11 END.
REQ-022 States: IDLE, FETCH, EXEC, PULSE, WAIT, CHECK, DONE.
REQ-023 IDLE/DONE with start=1: next edge -> FETCH; step index, fail_count and fail_step clear to 0.
REQ-024 FETCH: latch script[index] into the step register -> EXEC (1 cycle).
REQ-025 EXEC on SET_S: S_out updates on this edge -> WAIT.
REQ-026 EXEC on PULSE: Continue_n goes low on this edge -> PULSE.
REQ-027 EXEC on CHECK: -> WAIT. EXEC on END: -> DONE.
REQ-028 PULSE: Continue_n stays low for exactly PULSE_LEN cycles, then returns high -> WAIT.
REQ-029 WAIT: the counter loads wait and decrements each cycle; it exits when the counter reaches 0; wait=0 exits after 1 cycle.
REQ-030 WAIT exit: if op=CHECK -> CHECK, else advance the step index -> FETCH.
REQ-031 CHECK (1 cycle): if observe != data, increment fail_count (saturating); on the first mismatch, record fail_step = index; then advance -> FETCH.
REQ-032 If the last step executed is index DEPTH-1 and it is not END, the block goes to DONE instead of wrapping.
REQ-033 wr_en is honoured only when busy=0; writes while busy are ignored.
REQ-034 start while busy is ignored; the sequence cannot be retriggered mid-run.
REQ-035 S_out holds its last value in DONE and IDLE until the next SET_S or Reset.
REQ-036 Script memory contents are not cleared by Reset.

Reset
REQ-037 Reset asserted, at any time or state, sets within the same cycle: state IDLE, S_out 0, Continue_n 1, Run_n 1, busy 0, done 0, pass 0, fail_count 0, fail_step 0.
REQ-038 Reset during PULSE releases Continue_n to 1 immediately.

Configuration
REQ-039 Macro SEQ_STICKY_FAIL_EN: defined -> the first CHECK mismatch goes directly to DONE (fail_count=1, pass=0); undefined -> the sequence continues to END or DEPTH-1.

Verification
REQ-040 Script [SET_S 0x0003 wait 5, CHECK 0x0003 wait 2, END], observe tied 0x0003, start pulse -> S_out=0x0003, then done=1, pass=1, fail_count=0.
REQ-041 PULSE step, PULSE_LEN=10, wait 4 -> Continue_n low for exactly 10 cycles; next FETCH 4 cycles after release.
REQ-042 Three CHECK 0xFFFF steps, observe=0x0000, macro undefined -> fail_count=3, fail_step=0, pass=0; with SEQ_STICKY_FAIL_EN -> fail_count=1, DONE after step 0.
REQ-043 Full 32-step script of SET_S with no END -> DONE after step 31, S_out = step 31 data, no wrap to step 0.
REQ-044 Reset asserted mid-PULSE -> Continue_n=1, busy=0, S_out=0 same cycle; a restart replays the unchanged script.
REQ-045 wr_en to step 0 while busy, and start while busy -> the script and run are unaffected; the result is identical to an undisturbed run.

Source files
------------

// File: rtl/stim_sequencer.sv
// stim_sequencer: scripted switch-drive / continue-pulse / observe-check
// sequencer. A small script memory holds {op, wait, data} step words that are
// fetched and executed one by one after a start request.
// Optional build macro SEQ_STICKY_FAIL_EN: when defined, the first CHECK
// mismatch ends the run immediately (DONE); otherwise the run continues.
module stim_sequencer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 32,
  parameter int WAIT_W    = 16,
  parameter int PULSE_LEN = 10,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         start,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [2+WAIT_W+DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]            observe,
  output logic [DATA_W-1:0]            S_out,
  output logic                         Continue_n,
  output logic                         Run_n,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [7:0]                   fail_count,
  output logic [AW-1:0]                fail_step
);

  localparam int SW = 2 + WAIT_W + DATA_W;

  typedef enum logic [1:0] {
    OP_SET   = 2'b00,
    OP_PULSE = 2'b01,
    OP_CHECK = 2'b10,
    OP_END   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PULSE = 3'd3,
    S_WAIT  = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Script storage is deliberately outside the reset domain so a reset
  // between runs leaves the loaded script intact.
  logic [SW-1:0]     script [DEPTH];

  state_t            state;
  logic [SW-1:0]     step;
  logic [AW-1:0]     index;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        pulse_cnt;

  op_t               step_op;
  logic [WAIT_W-1:0] step_wait;
  logic [DATA_W-1:0] step_data;
  logic              last_step;
  logic              mismatch;
  logic              sticky_stop;
  logic [7:0]        fail_count_inc;

  assign step_op        = op_t'(step[SW-1 -: 2]);
  assign step_wait      = step[DATA_W +: WAIT_W];
  assign step_data      = step[DATA_W-1:0];
  assign last_step      = (index == AW'(DEPTH - 1));
  assign mismatch       = (observe != step_data);
  assign fail_count_inc = (fail_count == 8'hFF) ? 8'hFF : (fail_count + 8'd1);

`ifdef SEQ_STICKY_FAIL_EN
  assign sticky_stop = mismatch;
`else
  assign sticky_stop = 1'b0;
`endif

  // Script write port; writes are only accepted while the sequencer is idle.
  always_ff @(posedge Clk) begin
    if (wr_en && !busy) begin
      script[wr_addr] <= wr_data;
    end
  end

  // Sequencer FSM with all status outputs registered alongside the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      step       <= '0;
      index      <= '0;
      wait_cnt   <= '0;
      pulse_cnt  <= 8'd0;
      S_out      <= '0;
      Continue_n <= 1'b1;
      Run_n      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= 8'd0;
      fail_step  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_FETCH;
            index      <= '0;
            fail_count <= 8'd0;
            fail_step  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            Run_n      <= 1'b0;
          end
        end

        S_FETCH: begin
          step  <= script[index];
          state <= S_EXEC;
        end

        S_EXEC: begin
          case (step_op)
            OP_SET: begin
              S_out    <= step_data;
              wait_cnt <= step_wait;
              state    <= S_WAIT;
            end
            OP_PULSE: begin
              Continue_n <= 1'b0;
              pulse_cnt  <= 8'(PULSE_LEN - 1);
              state      <= S_PULSE;
            end
            OP_CHECK: begin
              wait_cnt <= step_wait;
              state    <= S_WAIT;
            end
            default: begin
              // END step
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              Run_n <= 1'b1;
              pass  <= (fail_count == 8'd0);
            end
          endcase
        end

        S_PULSE: begin
          // Continue_n was pulled low on the EXEC edge; release after
          // exactly PULSE_LEN cycles in this state.
          if (pulse_cnt == 8'd0) begin
            Continue_n <= 1'b1;
            wait_cnt   <= step_wait;
            state      <= S_WAIT;
          end else begin
            pulse_cnt <= pulse_cnt - 8'd1;
          end
        end

        S_WAIT: begin
          // A wait of 0 or 1 both last a single cycle; wait N lasts N cycles.
          if (wait_cnt <= WAIT_W'(1)) begin
            if (step_op == OP_CHECK) begin
              state <= S_CHECK;
            end else if (last_step) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              Run_n <= 1'b1;
              pass  <= (fail_count == 8'd0);
            end else begin
              index <= index + AW'(1);
              state <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end

        S_CHECK: begin
          if (mismatch) begin
            fail_count <= fail_count_inc;
            if (fail_count == 8'd0) begin
              fail_step <= index;
            end
          end
          if (sticky_stop || last_step) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Run_n <= 1'b1;
            pass  <= !mismatch && (fail_count == 8'd0);
          end else begin
            index <= index + AW'(1);
            state <= S_FETCH;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer: table of script scenarios run through
// a scoreboard queue, plus hand sequences for reset mid-pulse and busy-time
// disturbance. Honours SEQ_STICKY_FAIL_EN when defined.
module tb_stim_sequencer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int WAIT_W = 16;
  localparam int PLEN   = 10;
  localparam int AW     = 5;
  localparam int SW     = 2 + WAIT_W + DATA_W;

  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_PULSE = 2'b01;
  localparam logic [1:0] OP_CHECK = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              start;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [SW-1:0]     wr_data;
  logic [DATA_W-1:0] observe;
  logic [DATA_W-1:0] S_out;
  logic              Continue_n;
  logic              Run_n;
  logic              busy;
  logic              done;
  logic              pass;
  logic [7:0]        fail_count;
  logic [AW-1:0]     fail_step;

  always #5 Clk = ~Clk;

  stim_sequencer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_W(WAIT_W), .PULSE_LEN(PLEN)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .observe(observe),
    .S_out(S_out), .Continue_n(Continue_n), .Run_n(Run_n),
    .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_step(fail_step)
  );

  typedef struct {
    int          kind;
    logic [15:0] obs;
    logic [15:0] s;
    logic        pss;
    logic [7:0]  fc;
    logic [4:0]  fs;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        pss;
    logic [7:0]  fc;
    logic [4:0]  fs;
    int          cyc;
    int          lows;
  } exp_t;

  exp_t          exp_q[$];
  logic [SW-1:0] script_m [DEPTH];
  vec_t          tbl [6];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic put(input int a, input logic [1:0] op, input logic [15:0] w, input logic [15:0] d);
    @(negedge Clk);
    wr_en       = 1'b1;
    wr_addr     = a[4:0];
    wr_data     = {op, w, d};
    script_m[a] = {op, w, d};
    @(negedge Clk);
    wr_en = 1'b0;
  endtask

  task automatic load_kind(input int k);
    case (k)
      0: begin
        put(0, OP_SET, 16'd5, 16'h0003);
        put(1, OP_CHECK, 16'd2, 16'h0003);
        put(2, OP_END, 16'd0, 16'h0000);
      end
      1: begin
        for (int i = 0; i < 3; i++) put(i, OP_CHECK, 16'd0, 16'hFFFF);
        put(3, OP_END, 16'd0, 16'h0000);
      end
      2: begin
        for (int i = 0; i < DEPTH; i++) put(i, OP_SET, 16'(i % 3), 16'(i * 256 + 7));
      end
      3: begin
        put(0, OP_SET, 16'd1, 16'hA5A5);
        put(1, OP_CHECK, 16'd0, 16'hA5A5);
        put(2, OP_CHECK, 16'd3, 16'h1234);
        put(3, OP_PULSE, 16'd0, 16'h0000);
        put(4, OP_CHECK, 16'd2, 16'h5555);
        put(5, OP_END, 16'd0, 16'h0000);
      end
      4: begin
        put(0, OP_END, 16'd0, 16'h0000);
      end
      5: begin
        put(0, OP_PULSE, 16'd4, 16'h0000);
        put(1, OP_END, 16'd0, 16'h0000);
      end
      6: begin
        put(0, OP_SET, 16'd0, 16'h0F0F);
        put(1, OP_PULSE, 16'd2, 16'h0000);
        put(2, OP_END, 16'd0, 16'h0000);
      end
      default: begin
        put(0, OP_END, 16'd0, 16'h0000);
      end
    endcase
  endtask

  // Behavioural timing model: edges from the start edge until done, and
  // total Continue_n-low cycles, derived from the shadow script.
  function automatic void model_timing(input logic [15:0] obs, output int cyc, output int lows);
    logic [1:0]  op;
    logic [15:0] d;
    int          w;
    bit          sticky;
    sticky = 1'b0;
`ifdef SEQ_STICKY_FAIL_EN
    sticky = 1'b1;
`endif
    cyc  = 0;
    lows = 0;
    for (int i = 0; i < DEPTH; i++) begin
      op  = script_m[i][33:32];
      w   = int'(script_m[i][31:16]);
      d   = script_m[i][15:0];
      if (w < 1) w = 1;
      cyc += 2;
      if (op == OP_END) break;
      if (op == OP_PULSE) begin
        cyc  += PLEN;
        lows += PLEN;
      end
      cyc += w;
      if (op == OP_CHECK) begin
        cyc += 1;
        if (sticky && (obs != d)) break;
      end
    end
  endfunction

  task automatic run(input vec_t v, input bit disturb, input string tag);
    exp_t e;
    int   n;
    int   lows;
    int   runbad;
    e.s   = v.s;
    e.pss = v.pss;
    e.fc  = v.fc;
    e.fs  = v.fs;
    model_timing(v.obs, e.cyc, e.lows);
    exp_q.push_back(e);
    observe = v.obs;
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    n = 0; lows = 0; runbad = 0;
    do begin
      @(posedge Clk);
      n++;
      #1;
      if (!Continue_n) lows++;
      if (Run_n !== ~busy) runbad++;
      if (disturb && (n == 3 || n == 9)) begin
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = {OP_END, 16'd0, 16'h0000};
        start   = 1'b1;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
    end while (!done && n < 2000);
    wr_en = 1'b0;
    start = 1'b0;
    e = exp_q.pop_front();
    chk({tag, ".done"},       32'(done),       32'd1);
    chk({tag, ".cycles"},     32'(n),          32'(e.cyc));
    chk({tag, ".S_out"},      32'(S_out),      32'(e.s));
    chk({tag, ".pass"},       32'(pass),       32'(e.pss));
    chk({tag, ".fail_count"}, 32'(fail_count), 32'(e.fc));
    chk({tag, ".fail_step"},  32'(fail_step),  32'(e.fs));
    chk({tag, ".cont_low"},   32'(lows),       32'(e.lows));
    chk({tag, ".run_n"},      32'(runbad),     32'd0);
    chk({tag, ".busy_end"},   32'(busy),       32'd0);
  endtask

  initial begin
    int   n;
    vec_t v;
    Reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; observe = '0;
    for (int i = 0; i < DEPTH; i++) script_m[i] = '0;

    tbl[0] = '{0, 16'h0003, 16'h0003, 1'b1, 8'd0, 5'd0};
`ifdef SEQ_STICKY_FAIL_EN
    tbl[1] = '{1, 16'h0000, 16'h0003, 1'b0, 8'd1, 5'd0};
    tbl[3] = '{3, 16'hA5A5, 16'hA5A5, 1'b0, 8'd1, 5'd2};
`else
    tbl[1] = '{1, 16'h0000, 16'h0003, 1'b0, 8'd3, 5'd0};
    tbl[3] = '{3, 16'hA5A5, 16'hA5A5, 1'b0, 8'd2, 5'd2};
`endif
    tbl[2] = '{2, 16'h0000, 16'h1F07, 1'b1, 8'd0, 5'd0};
    tbl[4] = '{4, 16'hA5A5, 16'hA5A5, 1'b1, 8'd0, 5'd0};
    tbl[5] = '{5, 16'h0000, 16'hA5A5, 1'b1, 8'd0, 5'd0};

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst.S_out", 32'(S_out), 32'd0);
    chk("rst.Continue_n", 32'(Continue_n), 32'd1);
    chk("rst.Run_n", 32'(Run_n), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.pass", 32'(pass), 32'd0);
    chk("rst.fail_count", 32'(fail_count), 32'd0);
    chk("rst.fail_step", 32'(fail_step), 32'd0);

    for (int t = 0; t < 6; t++) begin
      load_kind(tbl[t].kind);
      run(tbl[t], 1'b0, $sformatf("vec%0d", t));
    end

    // Reset in the middle of a continue pulse.
    load_kind(6);
    observe = 16'h0000;
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
    n = 0;
    while (Continue_n !== 1'b0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("midpulse.seen", 32'(Continue_n), 32'd0);
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midpulse.Continue_n", 32'(Continue_n), 32'd1);
    chk("midpulse.busy", 32'(busy), 32'd0);
    chk("midpulse.S_out", 32'(S_out), 32'd0);
    chk("midpulse.Run_n", 32'(Run_n), 32'd1);
    @(negedge Clk);
    Reset = 1'b0;
    v = '{6, 16'h0000, 16'h0F0F, 1'b1, 8'd0, 5'd0};
    run(v, 1'b0, "restart");

    // Write and start attempts while busy must not change anything.
    load_kind(0);
    run(tbl[0], 1'b1, "disturbed");
    run(tbl[0], 1'b0, "after_disturb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
